// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// The package holds the FSM encoding, the requester count, the default parameters and a rotate helper.
package rr_arb4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int NREQ         = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_CNT_W    = 3;

    // Rotate right by sh. After rotation, bit 0 holds the requester that the pointer selects.
    function automatic logic [NREQ-1:0] rotr4(input logic [NREQ-1:0] v, input logic [1:0] sh);
        logic [2*NREQ-1:0] dbl;
        dbl = {v, v};
        return dbl[{1'b0, sh} +: NREQ];
    endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesting blocks (master) and the arbiter (slave).
interface rr_arb4_if;

    logic                           enable;
    logic [rr_arb4_pkg::NREQ-1:0]   req;
    logic [rr_arb4_pkg::NREQ-1:0]   gnt;
    logic [1:0]                     gnt_id;
    logic                           gnt_valid;
    logic                           handoff;

    modport master (
        output enable,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  handoff
    );

    modport slave (
        input  enable,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output handoff
    );

endinterface

// File: rtl/rr_arb4_prio_enc4.sv
// 4-to-2 priority encoder. The lowest set bit wins.
// The encoder returns index 00 with valid low when it is disabled or when its input is zero.
module prio_enc4 (
    input  logic       en_i,
    input  logic [3:0] vec_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 2'd0;
        valid_o = 1'b0;
        if (en_i) begin
            valid_o = |vec_i;
            if (vec_i[0])      idx_o = 2'd0;
            else if (vec_i[1]) idx_o = 2'd1;
            else if (vec_i[2]) idx_o = 2'd2;
            else if (vec_i[3]) idx_o = 2'd3;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter with registered grants for four requesters.
// An owner keeps the grant until it releases it or until its hold limit expires while another requester is waiting.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    rr_arb4_if.slave    arb
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [1:0]        id_q, id_d;
    logic              valid_q, valid_d;
    logic              handoff_q, handoff_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   candidates;
    logic [NREQ-1:0]   rotated;
    logic [1:0]        enc_idx;
    logic              enc_valid;
    logic [1:0]        winner;
    logic [NREQ-1:0]   win_onehot;
    logic              owner_req;
    logic              expire;
    logic              rearb;

    // ptr_q always equals owner+1 while a grant is held. A rotation by ptr_q with the owner
    // masked out therefore serves both the release and the expiry rearbitration.
    assign candidates = arb.req & ~gnt_q;
    assign rotated    = rotr4(candidates, ptr_q);

    prio_enc4 u_enc (
        .en_i    (arb.enable),
        .vec_i   (rotated),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign winner = enc_idx + ptr_q;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (winner == 2'(gi));
    end

    assign owner_req = arb.req[id_q];
    assign expire    = (cnt_q == HOLD_LAST) && (|candidates);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        valid_d   = valid_q;
        handoff_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rearb     = 1'b0;

        case (state_q)
            IDLE: begin
                rearb = arb.enable;
            end
            GRANT: begin
                if (!arb.enable) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                end else if (!owner_req || expire) begin
                    rearb = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rearb) begin
            if (enc_valid) begin
                state_d   = GRANT;
                gnt_d     = win_onehot;
                id_d      = winner;
                valid_d   = 1'b1;
                handoff_d = 1'b1;
                ptr_d     = winner + 2'd1;
                cnt_d     = '0;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = 2'd0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= 2'd0;
            valid_q   <= 1'b0;
            handoff_q <= 1'b0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            handoff_q <= handoff_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_id    = id_q;
    assign arb.gnt_valid = valid_q;
    assign arb.handoff   = handoff_q;

endmodule
